// File: rtl/alu_bit_serial_pkg.sv
// Shared constants and types for the bit-serial ALU.
package alu_bit_serial_pkg;

  localparam int unsigned ALU_W_DEF = 32;
  localparam int unsigned CTRL_W    = 4;

  // ALU_control codes: {A_invert, B_invert, op[1:0]}
  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_bit_serial_if.sv
// Request/response bundle between a requester and the bit-serial ALU.
interface alu_bit_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       alu_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output start, src1, src2, alu_control,
    input  busy, done, result, zero, cout, overflow
  );

  modport slave (
    input  start, src1, src2, alu_control,
    output busy, done, result, zero, cout, overflow
  );
endinterface

// File: rtl/serial_bit_cell.sv
// Combinational 1-bit ALU cell: optional operand inversion, AND/OR/ADD/less select.
module serial_bit_cell (
  input  logic       a,
  input  logic       b,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout,
  output logic       sum
);
  logic ai;
  logic bi;

  // Full adder plus op mux on the (possibly inverted) operands
  always_comb begin
    ai   = a ^ a_inv;
    bi   = b ^ b_inv;
    sum  = ai ^ bi ^ cin;
    cout = (ai & bi) | (ai & cin) | (bi & cin);
    res  = 1'b0;
    case (op)
      2'b00:   res = ai & bi;
      2'b01:   res = ai | bi;
      2'b10:   res = sum;
      default: res = less;
    endcase
  end
endmodule

// File: rtl/alu_bit_serial.sv
// Multi-cycle ALU: one bit per clock LSB first, carry rippled through a flop.
module alu_bit_serial
  import alu_bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_bit_serial_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              msb_cin_q, msb_cin_d;
  logic              msb_cout_q, msb_cout_d;
  logic              msb_sum_q, msb_sum_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              cout_q, cout_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cell_res;
  logic              cell_cout;
  logic              cell_sum;
  logic              last_bit;
  logic [WIDTH-1:0]  fix_res;

  serial_bit_cell u_cell (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .a_inv (ctrl_q[3]),
    .b_inv (ctrl_q[2]),
    .cin   (carry_q),
    .less  (1'b0),
    .op    (ctrl_q[1:0]),
    .res   (cell_res),
    .cout  (cell_cout),
    .sum   (cell_sum)
  );

  // Next-state, datapath and flag computation
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    shift_d    = shift_q;
    msb_cin_d  = msb_cin_q;
    msb_cout_d = msb_cout_q;
    msb_sum_d  = msb_sum_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    fix_res    = '0;
    last_bit   = (bit_idx_q == CNT_W'(WIDTH - 1));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          a_d       = bus.src1;
          b_d       = bus.src2;
          ctrl_d    = bus.alu_control;
          bit_idx_d = '0;
          carry_d   = bus.alu_control[2];
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d   = cell_cout;
        shift_d   = {cell_res, shift_q[WIDTH-1:1]};
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
        bit_idx_d = bit_idx_q + CNT_W'(1);
        if (last_bit) begin
          msb_cin_d  = carry_q;
          msb_cout_d = cell_cout;
          msb_sum_d  = cell_sum;
          state_d    = ST_FIX;
        end
      end
      ST_FIX: begin
        cout_d     = 1'b0;
        overflow_d = 1'b0;
        case (ctrl_q)
          CTRL_AND, CTRL_OR, CTRL_NOR: fix_res = shift_q;
          CTRL_ADD, CTRL_SUB: begin
            fix_res    = shift_q;
            cout_d     = msb_cout_q;
            overflow_d = msb_cin_q ^ msb_cout_q;
          end
          // Sign of the difference, corrected for signed overflow
          CTRL_SLT: fix_res = WIDTH'(msb_sum_q ^ msb_cin_q ^ msb_cout_q);
          default:  fix_res = '0;
        endcase
        result_d = fix_res;
        zero_d   = (fix_res == '0);
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      shift_q    <= '0;
      msb_cin_q  <= 1'b0;
      msb_cout_q <= 1'b0;
      msb_sum_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      shift_q    <= shift_d;
      msb_cin_q  <= msb_cin_d;
      msb_cout_q <= msb_cout_d;
      msb_sum_q  <= msb_sum_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu_bit_serial.sv
// Directed self-checking bench for the bit-serial ALU.
module tb_alu_bit_serial;
  import alu_bit_serial_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  alu_bit_serial_if #(.WIDTH(W)) bus ();

  alu_bit_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise start at a falling edge; lat counts falling edges until done is seen
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.src1        = a;
    bus.src2        = b;
    bus.alu_control = c;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_z,
                          input logic exp_c, input logic exp_v);
    int lat;
    do_op(c, a, b, lat);
    check_eq({tag, ".done"}, bus.done, 1'b1);
    check_eq({tag, ".lat"}, lat, 34);
    check_eq({tag, ".res"}, bus.result, exp_r);
    check_eq({tag, ".zero"}, bus.zero, exp_z);
    check_eq({tag, ".cout"}, bus.cout, exp_c);
    check_eq({tag, ".ovf"}, bus.overflow, exp_v);
    check_eq({tag, ".busy"}, bus.busy, 1'b0);
    @(negedge clk);
    check_eq({tag, ".pulse"}, bus.done, 1'b0);
    check_eq({tag, ".hold"}, bus.result, exp_r);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.src1        = '0;
    bus.src2        = '0;
    bus.alu_control = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy", bus.busy, 1'b0);
    check_eq("rst.done", bus.done, 1'b0);
    check_eq("rst.res", bus.result, 32'h0);
    check_eq("rst.zero", bus.zero, 1'b0);
    check_eq("rst.cout", bus.cout, 1'b0);
    check_eq("rst.ovf", bus.overflow, 1'b0);
    rst_n = 1'b1;

    check_op("add_ovf", CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    check_op("sub_eq",  CTRL_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    check_op("sub_neg", CTRL_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check_op("slt_lt",  CTRL_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check_op("slt_ovf", CTRL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check_op("nor",     CTRL_NOR, 32'h0F0F_0000, 32'h00F0_0000, 32'hF000_FFFF, 1'b0, 1'b0, 1'b0);
    check_op("and",     CTRL_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 1'b0, 1'b0, 1'b0);
    check_op("or",      CTRL_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check_op("add_wrap", CTRL_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    check_op("add_negovf", CTRL_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    check_op("undef", 4'b1010, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check_op("sub_ovf", CTRL_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a run discards the operation
    @(negedge clk);
    bus.start = 1'b1; bus.src1 = 32'd1; bus.src2 = 32'd1; bus.alu_control = CTRL_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("midrst.busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst.busy", bus.busy, 1'b0);
    check_eq("midrst.done", bus.done, 1'b0);
    check_eq("midrst.res", bus.result, 32'h0);
    check_eq("midrst.cout", bus.cout, 1'b0);
    check_eq("midrst.ovf", bus.overflow, 1'b0);
    check_eq("midrst.zero", bus.zero, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("midrst.no_done", seen, 0);
    check_op("after_rst", CTRL_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    // start while busy is ignored; operand changes after accept have no effect
    @(negedge clk);
    bus.start = 1'b1; bus.src1 = 32'd1; bus.src2 = 32'd2; bus.alu_control = CTRL_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    bus.start = 1'b1; bus.src1 = 32'd100; bus.src2 = 32'd200; bus.alu_control = CTRL_SUB;
    @(negedge clk);
    lat++;
    bus.start = 1'b0; bus.src1 = 32'hFFFF_FFFF;
    while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
    check_eq("ignore.lat", lat, 34);
    check_eq("ignore.res", bus.result, 32'd3);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("ignore.no_second", seen, 0);

    // Back-to-back: start presented during the done cycle
    do_op(CTRL_ADD, 32'd10, 32'd20, lat);
    check_eq("b2b.first_lat", lat, 34);
    check_eq("b2b.first_res", bus.result, 32'd30);
    bus.start = 1'b1; bus.src1 = 32'd100; bus.src2 = 32'd1; bus.alu_control = CTRL_SUB;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("b2b.busy", bus.busy, 1'b1);
    check_eq("b2b.first_hold", bus.result, 32'd30);
    lat = 0;
    while (!bus.done && lat < 100) begin @(negedge clk); lat++; end
    check_eq("b2b.second_lat", lat, 33);
    check_eq("b2b.second_res", bus.result, 32'd99);
    check_eq("b2b.second_cout", bus.cout, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
